// File: rtl/period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : period_meter
// Brief    : One-shot period / high-time meter for a slow asynchronous input,
//            results handed off over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module period_meter #(
  parameter int          WIDTH       = 32,
  parameter int unsigned TIMEOUT     = 50000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  input  logic             ready,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] c_CNT_LAST = WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       w_cnt_next;
  logic [WIDTH-1:0]       w_cnt_inc;
  logic [WIDTH-1:0]       r_high;
  logic [WIDTH-1:0]       w_high_next;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       w_period_next;
  logic [WIDTH-1:0]       r_high_out;
  logic [WIDTH-1:0]       w_high_out_next;
  logic                   w_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_high     <= '0;
      r_period   <= '0;
      r_high_out <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_high     <= w_high_next;
      r_period   <= w_period_next;
      r_high_out <= w_high_out_next;
    end
  end

  // An edge always takes priority over the timeout check in the same cycle.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_high_next     = r_high;
    w_period_next   = r_period;
    w_high_out_next = r_high_out;
    w_timeout       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_ARM;
          w_cnt_next   = '0;
        end
      end
      ST_ARM: begin
        w_cnt_next = w_cnt_inc;
        if (w_rise) begin
          w_state_next = ST_MEASURE;
          w_cnt_next   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        w_cnt_next = w_cnt_inc;
        if (w_fall) begin
          w_high_next = w_cnt_inc;
        end
        if (w_rise) begin
          w_period_next   = w_cnt_inc;
          w_high_out_next = r_high;
          w_state_next    = ST_HOLD;
        end else if (r_cnt == c_CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign busy       = (r_state != ST_IDLE);
  assign valid      = (r_state == ST_HOLD);
  assign timeout    = w_timeout;
  assign period_out = r_period;
  assign high_out   = r_high_out;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_period_meter
// Brief    : Self-checking bench for period_meter (two instances, TIMEOUT 100/12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_period_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        a_busy, a_valid, a_to;
  logic [15:0] a_period, a_high;
  logic        b_busy, b_valid, b_to;
  logic [15:0] b_period, b_high;

  int n_checks = 0;
  int n_fail   = 0;

  int   gen_high  = 5;
  int   gen_low   = 5;
  int   gen_phase = 3;
  bit   gen_en    = 1'b0;
  logic gen_level = 1'b0;
  int   cur_p     = 1;

  typedef struct {
    string name;
    int    high;
    int    low;
    int    phase;
    int    exp_period;
    int    exp_high;
    bit    a_to;
    bit    b_to;
  } vec_t;

  vec_t vecs[7];

  period_meter #(.WIDTH(16), .TIMEOUT(100), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start), .busy(a_busy),
    .period_out(a_period), .high_out(a_high), .valid(a_valid), .ready(ready),
    .timeout(a_to)
  );

  period_meter #(.WIDTH(16), .TIMEOUT(12), .SYNC_STAGES(3)) u_dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start), .busy(b_busy),
    .period_out(b_period), .high_out(b_high), .valid(b_valid), .ready(ready),
    .timeout(b_to)
  );

  always #5 clk = ~clk;

  // Waveform source: transitions land gen_phase ns after a clk edge, i.e. mid-cycle.
  initial begin
    forever begin
      if (gen_en) begin
        @(posedge clk); #(gen_phase); sig_in = 1'b1;
        repeat (gen_high - 1) @(posedge clk);
        @(posedge clk); #(gen_phase); sig_in = 1'b0;
        repeat (gen_low - 1) @(posedge clk);
      end else begin
        @(posedge clk); #(gen_phase); sig_in = gen_level;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_gen(input bit en, input int h, input int l, input int ph, input logic lvl);
    int old_p;
    old_p     = cur_p;
    gen_en    = en;
    gen_high  = h;
    gen_low   = l;
    gen_phase = ph;
    gen_level = lvl;
    cur_p     = en ? (h + l) : 1;
    repeat (old_p + cur_p + 6) tick();
  endtask

  task automatic run_measure(input string nm, input int h, input int l, input int ph,
                             input int exp_p, input int exp_h, input bit a_exp_to,
                             input bit b_exp_to);
    int          a_nv, a_nt, b_nv, b_nt;
    logic [15:0] a_p, a_h, b_p, b_h, a_prev, b_prev;
    a_nv = 0; a_nt = 0; b_nv = 0; b_nt = 0;
    a_p = '0; a_h = '0; b_p = '0; b_h = '0;
    set_gen(1'b1, h, l, ph, 1'b0);
    a_prev = a_period;
    b_prev = b_period;
    ready  = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 3 * (h + l) + 120; i++) begin
      if (a_valid) begin a_nv++; a_p = a_period; a_h = a_high; end
      if (a_to) a_nt++;
      if (b_valid) begin b_nv++; b_p = b_period; b_h = b_high; end
      if (b_to) b_nt++;
      tick();
    end
    check({nm, " a.valid_cycles"}, a_nv, a_exp_to ? 0 : 1);
    check({nm, " a.timeouts"}, a_nt, a_exp_to ? 1 : 0);
    if (a_exp_to) begin
      check({nm, " a.period_kept"}, a_period, a_prev);
    end else begin
      check({nm, " a.period"}, a_p, exp_p);
      check({nm, " a.high"}, a_h, exp_h);
    end
    check({nm, " a.busy_end"}, a_busy, 0);
    check({nm, " b.valid_cycles"}, b_nv, b_exp_to ? 0 : 1);
    check({nm, " b.timeouts"}, b_nt, b_exp_to ? 1 : 0);
    if (b_exp_to) begin
      check({nm, " b.period_kept"}, b_period, b_prev);
    end else begin
      check({nm, " b.period"}, b_p, exp_p);
      check({nm, " b.high"}, b_h, exp_h);
    end
    check({nm, " b.busy_end"}, b_busy, 0);
  endtask

  task automatic arm_timeout(input string nm, input logic lvl);
    int a_at, b_at, a_nt, b_nt, nv;
    a_at = -1; b_at = -1; a_nt = 0; b_nt = 0; nv = 0;
    set_gen(1'b0, 1, 1, 3, lvl);
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, " busy_after_start"}, a_busy, 1);
    // Sample i is the i-th cycle after ARM entry; cnt equals i-1 there.
    for (int i = 1; i <= 150; i++) begin
      if (a_to) begin a_nt++; if (a_at < 0) a_at = i; end
      if (b_to) begin b_nt++; if (b_at < 0) b_at = i; end
      if (a_valid || b_valid) nv++;
      tick();
    end
    check({nm, " a.timeout_cycle"}, a_at, 100);
    check({nm, " a.timeout_count"}, a_nt, 1);
    check({nm, " b.timeout_cycle"}, b_at, 12);
    check({nm, " b.timeout_count"}, b_nt, 1);
    check({nm, " valid_seen"}, nv, 0);
    check({nm, " a.busy_end"}, a_busy, 0);
  endtask

  initial begin
    int h, l, n_v, n_t;

    vecs[0] = '{"ideal_50",      5,  5, 3,  10,  5, 1'b0, 1'b0};
    vecs[1] = '{"skewed_duty",   3,  7, 5,  10,  3, 1'b0, 1'b0};
    vecs[2] = '{"collision_b",   6,  6, 4,  12,  6, 1'b0, 1'b0};
    vecs[3] = '{"over_b",        6,  7, 4,  13,  6, 1'b0, 1'b1};
    vecs[4] = '{"collision_a",  12, 88, 2, 100, 12, 1'b0, 1'b1};
    vecs[5] = '{"over_a",       50, 51, 6, 101, 50, 1'b1, 1'b1};
    vecs[6] = '{"fast",          2,  2, 7,   4,  2, 1'b0, 1'b0};

    reset = 1'b0;
    tick(); tick();
    check("reset busy", a_busy, 0);
    check("reset valid", a_valid, 0);
    check("reset timeout", a_to, 0);
    check("reset period", a_period, 0);
    check("reset high", a_high, 0);
    reset = 1'b1;
    tick();

    foreach (vecs[k]) begin
      run_measure(vecs[k].name, vecs[k].high, vecs[k].low, vecs[k].phase,
                  vecs[k].exp_period, vecs[k].exp_high, vecs[k].a_to, vecs[k].b_to);
    end

    // Random steady waveforms against the reference rule: period=H+L, high=H, abort if P>T.
    for (int r = 0; r < 8; r++) begin
      h = $urandom_range(40, 2);
      l = $urandom_range(40, 2);
      run_measure($sformatf("rand%0d_%0d_%0d", r, h, l), h, l, $urandom_range(8, 2),
                  h + l, h, (h + l) > 100, (h + l) > 12);
    end

    arm_timeout("arm_low", 1'b0);
    arm_timeout("arm_high", 1'b1);

    // Backpressure: results must stay frozen while start and the input rate change.
    set_gen(1'b1, 5, 5, 3, 1'b0);
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !a_valid; i++) tick();
    check("bp valid_reached", a_valid, 1);
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(1, 0));
      if (i == 5) begin gen_high = 2; gen_low = 3; end
      tick();
      check("bp valid_held", a_valid, 1);
      check("bp period_held", a_period, 10);
      check("bp high_held", a_high, 5);
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    check("bp accepted", a_valid, 0);
    check("bp busy_after", a_busy, 0);
    repeat (3) tick();
    check("bp no_rearm", a_busy, 0);
    cur_p = 10;

    // Reset while measuring, between the arming rise and the closing rise.
    set_gen(1'b1, 20, 20, 4, 1'b0);
    ready = 1'b1;
    @(posedge sig_in);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(posedge sig_in);
    repeat (10) tick();
    check("rst_mid pre_busy", a_busy, 1);
    reset = 1'b0;
    #1;
    check("rst_mid busy", a_busy, 0);
    check("rst_mid valid", a_valid, 0);
    check("rst_mid timeout", a_to, 0);
    check("rst_mid period", a_period, 0);
    check("rst_mid high", a_high, 0);
    tick(); tick();
    reset = 1'b1;
    n_v = 0; n_t = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_valid || b_valid) n_v++;
      if (a_to || b_to) n_t++;
      tick();
    end
    check("rst_mid no_valid", n_v, 0);
    check("rst_mid no_timeout", n_t, 0);
    run_measure("after_reset", 20, 20, 4, 40, 20, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
